// File: rtl/calendar_date_ctr.sv
// BCD calendar date counter: day/month/year with leap-year handling, validated
// parallel load, year carry-out pulse and a four-digit display mux.
module calendar_date_ctr #(
    parameter int          YEAR_DIGITS = 4,
    parameter logic [7:0]  CENTURY_BCD = 8'h20,
    parameter logic [15:0] INIT_YEAR   = 16'h2000,
    parameter logic [7:0]  INIT_MONTH  = 8'h01,
    parameter logic [7:0]  INIT_DAY    = 8'h01,
    parameter bit          LEAP_EN     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_day,
    input  logic                     load,
    input  logic [4*YEAR_DIGITS-1:0] load_year,
    input  logic [7:0]               load_month,
    input  logic [7:0]               load_day,
    input  logic                     disp_mode,
    output logic [4*YEAR_DIGITS-1:0] year_bcd,
    output logic [7:0]               month_bcd,
    output logic [7:0]               day_bcd,
    output logic                     leap,
    output logic                     co_year,
    output logic                     load_ack,
    output logic                     load_err,
    output logic [15:0]              digits
);
    localparam int YW = 4 * YEAR_DIGITS;

    logic [YW-1:0] year_r, year_n;
    logic [7:0]    month_r, month_n, day_r, day_n;
    logic          co_n, ack_n, err_n;
    logic          load_leap, load_ok;
    logic [7:0]    cur_len, load_len;
    logic [15:0]   year_disp;

    // Divisible by 4 straight from two BCD digits: parity of tens picks the units set.
    function automatic logic div4(input logic [7:0] t);
        if (t[4]) return (t[3:0] == 4'd2) || (t[3:0] == 4'd6);
        return (t[3:0] == 4'd0) || (t[3:0] == 4'd4) || (t[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [YW-1:0] y);
        logic [15:0] yp;
        yp = 16'(y);
        if (!LEAP_EN) return 1'b0;
        if (YEAR_DIGITS == 2 || yp[7:0] != 8'h00) return div4(yp[7:0]);
        return div4(yp[15:8]);  // century years: leap only when divisible by 400
    endfunction

    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
        case (m)
            8'h02:                      return lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [YW-1:0] inc_year(input logic [YW-1:0] y);
        logic [YW-1:0] r;
        logic          c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++)
            if (c) begin
                if (y[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = y[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        return r;
    endfunction

    assign leap      = is_leap(year_r);
    assign cur_len   = month_len(month_r, leap);
    assign load_leap = is_leap(load_year);
    assign load_len  = month_len(load_month, load_leap);
    assign load_ok   = bcd_ok(16'(load_year)) && bcd_ok({load_month, load_day})
                    && load_month >= 8'h01 && load_month <= 8'h12
                    && load_day != 8'h00 && load_day <= load_len;

    always_comb begin
        year_n  = year_r;
        month_n = month_r;
        day_n   = day_r;
        co_n    = 1'b0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        if (load) begin
            // a coincident tick is dropped; load takes priority
            if (load_ok) begin
                year_n  = load_year;
                month_n = load_month;
                day_n   = load_day;
                ack_n   = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else if (tick_day) begin
            if (day_r != cur_len) begin
                day_n = inc8(day_r);
            end else begin
                day_n = 8'h01;
                if (month_r != 8'h12) begin
                    month_n = inc8(month_r);
                end else begin
                    month_n = 8'h01;
                    year_n  = inc_year(year_r);
                    co_n    = (year_r == {YEAR_DIGITS{4'h9}});
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            year_r   <= INIT_YEAR[YW-1:0];
            month_r  <= INIT_MONTH;
            day_r    <= INIT_DAY;
            co_year  <= 1'b0;
            load_ack <= 1'b0;
            load_err <= 1'b0;
        end else begin
            year_r   <= year_n;
            month_r  <= month_n;
            day_r    <= day_n;
            co_year  <= co_n;
            load_ack <= ack_n;
            load_err <= err_n;
        end
    end

    assign year_bcd  = year_r;
    assign month_bcd = month_r;
    assign day_bcd   = day_r;
    assign year_disp = (YEAR_DIGITS == 2) ? {CENTURY_BCD, year_r[7:0]} : 16'(year_r);
    assign digits    = disp_mode ? year_disp : {month_r, day_r};
endmodule

// File: tb/tb_calendar_date_ctr.sv
// Bench for calendar_date_ctr: integer-calendar model checked every cycle on the
// 4-digit instance, plus literal directed checks and a 2-digit instance.
module tb_calendar_date_ctr;
    logic        clk, rst;
    logic        tick_day, load, disp_mode;
    logic [15:0] load_year;
    logic [7:0]  load_month, load_day;
    logic [15:0] year_bcd, digits;
    logic [7:0]  month_bcd, day_bcd;
    logic        leap, co_year, load_ack, load_err;

    logic        tick2, load2, disp2;
    logic [7:0]  ly2, lm2, ld2, year2, month2, day2;
    logic [15:0] digits2;
    logic        leap2, co2, ack2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    calendar_date_ctr u_dut (
        .clk(clk), .rst(rst), .tick_day(tick_day), .load(load),
        .load_year(load_year), .load_month(load_month), .load_day(load_day),
        .disp_mode(disp_mode), .year_bcd(year_bcd), .month_bcd(month_bcd),
        .day_bcd(day_bcd), .leap(leap), .co_year(co_year), .load_ack(load_ack),
        .load_err(load_err), .digits(digits)
    );

    calendar_date_ctr #(.YEAR_DIGITS(2), .CENTURY_BCD(8'h20)) u_dut2 (
        .clk(clk), .rst(rst), .tick_day(tick2), .load(load2),
        .load_year(ly2), .load_month(lm2), .load_day(ld2),
        .disp_mode(disp2), .year_bcd(year2), .month_bcd(month2),
        .day_bcd(day2), .leap(leap2), .co_year(co2), .load_ack(ack2),
        .load_err(err2), .digits(digits2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            if (b[4*i +: 4] > 4'd9) return -1;
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit is_leap_m(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int dim(input int m, input int y);
        if (m == 2) return is_leap_m(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic bit load_valid(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
        int yi, mi, di;
        yi = bcd2int(y);
        mi = bcd2int({8'h00, m});
        di = bcd2int({8'h00, d});
        if (yi < 0 || mi < 0 || di < 0) return 1'b0;
        if (mi < 1 || mi > 12) return 1'b0;
        return di >= 1 && di <= dim(mi, yi);
    endfunction

    // Model of the 4-digit instance in plain integers
    int m_y, m_m, m_d;
    bit m_co, m_ack, m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_y <= 2000; m_m <= 1; m_d <= 1;
            m_co <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
        end else begin
            m_co <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
            if (load) begin
                if (load_valid(load_year, load_month, load_day)) begin
                    m_y <= bcd2int(load_year);
                    m_m <= bcd2int({8'h00, load_month});
                    m_d <= bcd2int({8'h00, load_day});
                    m_ack <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (tick_day) begin
                if (m_d < dim(m_m, m_y)) m_d <= m_d + 1;
                else begin
                    m_d <= 1;
                    if (m_m < 12) m_m <= m_m + 1;
                    else begin
                        m_m  <= 1;
                        m_y  <= (m_y + 1) % 10000;
                        m_co <= (m_y == 9999);
                    end
                end
            end
        end
    end

    logic [15:0] ey, em, ed;
    always @(posedge clk) begin
        #1;
        ey = int2bcd(m_y);
        em = int2bcd(m_m);
        ed = int2bcd(m_d);
        chk("m_year", year_bcd, ey);
        chk("m_month", month_bcd, em);
        chk("m_day", day_bcd, ed);
        chk("m_leap", leap, is_leap_m(m_y));
        chk("m_co_year", co_year, m_co);
        chk("m_load_ack", load_ack, m_ack);
        chk("m_load_err", load_err, m_err);
        chk("m_digits", digits, disp_mode ? ey : {em[7:0], ed[7:0]});
    end

    task automatic do_load(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
        @(negedge clk);
        load = 1'b1; load_year = y; load_month = m; load_day = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick_day = 1'b1;
        @(negedge clk);
        tick_day = 1'b0;
    endtask

    function automatic logic [31:0] date();
        return {year_bcd, month_bcd, day_bcd};
    endfunction

    initial begin
        rst = 1'b0; tick_day = 1'b0; load = 1'b0; disp_mode = 1'b0;
        load_year = 16'h0; load_month = 8'h0; load_day = 8'h0;
        tick2 = 1'b0; load2 = 1'b0; disp2 = 1'b1; ly2 = 8'h0; lm2 = 8'h0; ld2 = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", load_ack, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("reset_date", date(), 32'h2000_0101);
        chk("reset_leap", leap, 1'b1);
        chk("reset_digits_md", digits, 16'h0101);
        disp_mode = 1'b1;
        #1 chk("reset_digits_y", digits, 16'h2000);
        @(negedge clk);
        disp_mode = 1'b0;

        do_load(16'h2023, 8'h01, 8'h31);
        chk("ack_2023_01_31", load_ack, 1'b1);
        do_tick();
        chk("jan_rollover", date(), 32'h2023_0201);
        do_load(16'h2023, 8'h02, 8'h28);
        do_tick();
        chk("feb_nonleap", date(), 32'h2023_0301);

        do_load(16'h2024, 8'h02, 8'h28);
        do_tick();
        chk("feb28_2024", date(), 32'h2024_0229);
        do_tick();
        chk("feb29_2024", date(), 32'h2024_0301);
        do_load(16'h1900, 8'h02, 8'h28);
        chk("leap_1900", leap, 1'b0);
        do_tick();
        chk("feb_1900", date(), 32'h1900_0301);
        do_load(16'h2000, 8'h02, 8'h28);
        do_tick();
        chk("feb_2000", date(), 32'h2000_0229);

        do_load(16'h9999, 8'h12, 8'h31);
        do_tick();
        chk("year_wrap", date(), 32'h0000_0101);
        chk("co_pulse", co_year, 1'b1);
        chk("leap_0000", leap, 1'b1);
        @(negedge clk);
        chk("co_one_cycle", co_year, 1'b0);

        do_load(16'h2023, 8'h02, 8'h29);
        chk("err_feb29", load_err, 1'b1);
        do_load(16'h2023, 8'h13, 8'h01);
        chk("err_month13", load_err, 1'b1);
        do_load(16'h2023, 8'h04, 8'h31);
        chk("err_apr31", load_err, 1'b1);
        do_load(16'h2023, 8'h01, 8'h1A);
        chk("err_bcd", load_err, 1'b1);
        chk("err_unchanged", date(), 32'h0000_0101);

        @(negedge clk);
        load = 1'b1; tick_day = 1'b1;
        load_year = 16'h2024; load_month = 8'h12; load_day = 8'h31;
        @(negedge clk);
        load = 1'b0; tick_day = 1'b0;
        chk("load_wins", date(), 32'h2024_1231);
        chk("load_wins_ack", load_ack, 1'b1);
        chk("load_no_co", co_year, 1'b0);

        do_load(16'h2024, 8'h12, 8'h30);
        tick_day = 1'b1;
        @(negedge clk);
        tick_day = 1'b0;
        chk("tick_during_ack", date(), 32'h2024_1231);

        @(negedge clk);
        load = 1'b1; load_year = 16'h2011; load_month = 8'h11; load_day = 8'h11;
        #2 rst = 1'b0;
        @(negedge clk);
        load = 1'b0;
        chk("midload_rst_date", date(), 32'h2000_0101);
        rst = 1'b1;
        @(negedge clk);
        chk("midload_no_ack", load_ack, 1'b0);
        chk("midload_no_err", load_err, 1'b0);

        @(negedge clk);
        load2 = 1'b1; ly2 = 8'h99; lm2 = 8'h12; ld2 = 8'h31;
        @(negedge clk);
        load2 = 1'b0;
        chk("y2_ack", ack2, 1'b1);
        chk("y2_digits99", digits2, 16'h2099);
        tick2 = 1'b1;
        @(negedge clk);
        tick2 = 1'b0;
        chk("y2_wrap", {year2, month2, day2}, 24'h00_0101);
        chk("y2_co", co2, 1'b1);
        chk("y2_digits", digits2, 16'h2000);
        chk("y2_leap", leap2, 1'b1);
        @(negedge clk);
        chk("y2_co_one", co2, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calendar_date_ctr.md
CALENDAR_DATE_CTR -- requirements
Module: calendar_date_ctr

Interface
REQ-001 Parameter YEAR_DIGITS, default 4: year width in BCD digits; legal values 2 or 4.
REQ-002 Parameter CENTURY_BCD, default 8'h20: fixed upper year digits shown when YEAR_DIGITS=2.
REQ-003 Parameter INIT_YEAR, default 16'h2000: reset year, BCD; only the low 8 bits are used when YEAR_DIGITS=2.
REQ-004 Parameter INIT_MONTH, default 8'h01: reset month, BCD.
REQ-005 Parameter INIT_DAY, default 8'h01: reset day, BCD.
REQ-006 Parameter LEAP_EN, default 1: 1 enables leap-year Feb 29; 0 makes February always 28 days.
REQ-007 clk  in  1  single system clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 tick_day  in  1  one-cycle day-advance enable.
REQ-010 load  in  1  one-cycle request to set the date from the load_* buses.
REQ-011 load_year  in  4*YEAR_DIGITS  BCD year to load.
REQ-012 load_month  in  8  BCD month to load.
REQ-013 load_day  in  8  BCD day to load.
REQ-014 disp_mode  in  1  selects digits: 0 = month.day, 1 = year.
REQ-015 year_bcd  out  4*YEAR_DIGITS  current year.
REQ-016 month_bcd  out  8  current month, 01-12.
REQ-017 day_bcd  out  8  current day, 01-31.
REQ-018 leap  out  1  current year is a leap year.
REQ-019 co_year  out  1  one-cycle pulse on the year wrap to all zeros.
REQ-020 load_ack  out  1  one-cycle pulse when a load is accepted.
REQ-021 load_err  out  1  one-cycle pulse when a load is rejected.
REQ-022 digits  out  16  four BCD digits for the SSD path, MSD first.

Function
REQ-023 All counters SHALL be BCD; no digit SHALL ever hold a value above 9.
REQ-024 tick_day=1 SHALL advance the day by one on the same clock edge, so new values are visible the next cycle.
REQ-025 Month lengths SHALL be fixed as follows:
- 31 days: months 01, 03, 05, 07, 08, 10, 12.
- 30 days: months 04, 06, 09, 11.
- 28 days: month 02; 29 when leap=1.
REQ-026 When the current day equals the month length, a tick SHALL set day=01 and increment the month.
REQ-027 At month 12 that rollover SHALL set month=01 and increment the year.
REQ-028 The year SHALL wrap from all 9s to all 0s, and co_year SHALL pulse in that same cycle.
REQ-029 leap SHALL be combinational from year_bcd and LEAP_EN.
REQ-030 For YEAR_DIGITS=2, leap SHALL be set when the two-digit year is divisible by 4.
REQ-031 For YEAR_DIGITS=4, leap SHALL follow the Gregorian rule: divisible by 4 and (not divisible by 100, or divisible by 400).
REQ-032 Divisibility by 4 SHALL be decoded directly from BCD: tens digit even with units in {0,4,8}, or tens digit odd with units in {2,6}.
REQ-033 A load SHALL be validated in the cycle it is asserted; a load is valid only when all of the following hold:
- all digits are legal BCD;
- month is 01-12;
- day is from 01 to the month length, with leap evaluated on load_year.
REQ-034 A valid load SHALL update all date registers at the clock edge and pulse load_ack for the following cycle.
REQ-035 An invalid load SHALL leave all registers unchanged and pulse load_err for the following cycle.
REQ-036 When load and tick_day are asserted in the same cycle, load SHALL win and the tick SHALL be discarded.
REQ-037 A load SHALL never generate co_year.
REQ-038 digits SHALL be combinational from the current registers:
- disp_mode=0: {month_bcd, day_bcd}.
- disp_mode=1, YEAR_DIGITS=4: year_bcd.
- disp_mode=1, YEAR_DIGITS=2: {CENTURY_BCD, year_bcd}.
REQ-039 A tick arriving while load_ack or load_err is high SHALL be processed normally.

Reset
REQ-040 While rst=0, the block SHALL asynchronously force year=INIT_YEAR, month=INIT_MONTH, day=INIT_DAY.
REQ-041 While rst=0, the block SHALL asynchronously force co_year=0, load_ack=0, load_err=0.
REQ-042 Release of rst SHALL take effect at the next clock edge; no tick or load SHALL be processed while rst=0.
REQ-043 Assertion of rst in the middle of a load SHALL cancel it, with no ack or err pulse.
REQ-044 Illegal INIT_* parameter values SHALL be a configuration error; behaviour under them is undefined.

Verification
REQ-045 Defaults, rst low then high, no ticks -> year=2000, month=01, day=01, leap=1; digits=0101 (mode 0) and 2000 (mode 1).
REQ-046 Load 2023-01-31, one tick -> 2023-02-01; load 2023-02-28, one tick -> 2023-03-01.
REQ-047 Load 2024-02-28, two ticks -> 2024-02-29 then 2024-03-01; load 1900-02-28, one tick -> 1900-03-01; load 2000-02-28, one tick -> 2000-02-29.
REQ-048 Load 9999-12-31, one tick -> 0000-01-01, co_year high exactly one cycle, leap=1.
REQ-049 Each of these loads -> load_err pulse and registers unchanged:
- 2023-02-29;
- 2023-13-01;
- 2023-04-31;
- day=8'h1A (illegal BCD).
REQ-050 load=1 and tick_day=1 together with 2024-12-31 -> date 2024-12-31, load_ack pulse, no increment.
REQ-051 YEAR_DIGITS=2, CENTURY_BCD=8'h20, load 99-12-31, one tick -> year=00, co_year pulse, digits=2000 (mode 1).
